lab3_sbrb_latch_ctrl: RTL and testbench
=======================================

# lab3_sbrb_latch_ctrl

Sequencer and arbiter for a bank of gate-level active-low SbRb latches. It accepts set/clear requests from two requesters (A, B) and grants them round-robin. For each granted request it drives one latch with a registered active-low Sb or Rb pulse of programmable width, followed by a recovery cycle. It never presents Sb=Rb=0 (the forbidden input) to any latch. It sits between control logic and the latch bank; the latch outputs are optionally fed back for write checking.

## Interface
- `N`, 4: number of latches in the bank (1..256).
- `IW`, 2: index width; must satisfy 2^IW >= N.
- `PULSE_W`, 2: active-low pulse width in clock cycles (1..255).

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_a`  in  1  requester A request; hold high until `ack_a`.
- `op_a`  in  1  A operation: 1 = set (pulse Sb), 0 = clear (pulse Rb).
- `idx_a`  in  IW  A target latch index.
- `req_b`, `op_b`, `idx_b`  in  1/1/IW  same signals for requester B.
- `ack_a`, `ack_b`  out  1  one-cycle completion strobe to each requester.
- `busy`  out  1  high in every state except IDLE.
- `sb_n`  out  N  active-low set lines, one per latch.
- `rb_n`  out  N  active-low reset lines, one per latch.
- `q_in`  in  N  latch Q feedback (used only with the verify feature).
- `err`  out  1  sticky write-check failure.

## Operation
- FSM states: IDLE, PULSE, RECOV, ACK. All outputs are registered.
- IDLE:
  - If any `req_x` is high, latch the winner's op/idx into the grant registers, load the pulse counter with `PULSE_W`, and go to PULSE.
  - If the latched idx >= N, go directly to ACK instead (no-op; no pulse, no err).
- Arbitration:
  - With a single request, that requester wins.
  - With both requesting, the one not granted last wins.
  - The `last` pointer resets to B, so A wins the first tie.
- PULSE:
  - Drive `sb_n[idx]=0` (op=1) or `rb_n[idx]=0` (op=0). All other bits stay 1.
  - Decrement the counter; leave for RECOV when it reaches 1 (exactly `PULSE_W` cycles low).
- RECOV: all `sb_n`/`rb_n` high for one cycle; go to ACK.
- ACK: assert `ack` for the granted requester for one cycle, update `last`, go to IDLE.
- Request inputs are ignored outside IDLE. Requests changing mid-operation have no effect on the current grant.
- A `req_x` still high in the IDLE cycle after its ack is treated as a new request.
- Invariant: for every bit i, `sb_n[i] | rb_n[i]` = 1 at all times, and at most one bit of `sb_n & rb_n` is low.

## Timing
- Reset values (asynchronous, immediate):
  - `sb_n` = all 1, `rb_n` = all 1.
  - `ack_a` = `ack_b` = 0, `busy` = 0, `err` = 0.
  - State IDLE, `last` = B.
- A request sampled at edge E0 produces:
  - pulse lines low from after E0 through edge E0+PULSE_W;
  - RECOV for the following cycle;
  - ack high between edges E0+PULSE_W+1 and E0+PULSE_W+2;
  - IDLE after edge E0+PULSE_W+2.
- Service time per request is `PULSE_W`+3 cycles. Back-to-back requests complete every `PULSE_W`+3 cycles.
- Out-of-range idx: ack is asserted in the cycle after the sampling edge.
- Reset mid-PULSE: the pulse line returns high immediately and the request is dropped without an ack. The requester must re-issue it.

## Configuration
- `LAB3_SBRB_VERIFY_EN` defined:
  - In RECOV, sample `q_in[idx]`.
  - If it differs from op, set `err`; `err` stays high until `rst_n`.
  - The ack is still issued.
- Not defined: `q_in` is ignored and `err` is tied to 0.

## Test plan
- Reset, then A requests set idx=2 (`PULSE_W`=2) -> `sb_n`=4'b1011 for exactly 2 cycles, `rb_n`=4'b1111 throughout, `ack_a` 1 cycle at E0+3, `busy` high 4 cycles.
- A and B request simultaneously (A clear idx0, B set idx1) -> A served first (`rb_n`=4'b1110), then B (`sb_n`=4'b1101). Each ack occurs once; 10 cycles total.
- B holds req continuously while A requests once -> B and A alternate. Assert the invariant that no bit ever has `sb_n`=`rb_n`=0.
- Out-of-range request idx=5 with N=4, IW=3 -> no pulse line ever low, ack one cycle after sampling, `err`=0.
- Deassert `rst_n` during PULSE -> `sb_n`/`rb_n` go all-1 without a clock edge, no ack; the next request is serviced normally.
- With `LAB3_SBRB_VERIFY_EN`, set idx1 while `q_in` is held at 0 -> `err`=1 after RECOV and stays 1 across later good writes until reset. Without the macro, `err` stays 0.

Source files
------------

// File: rtl/lab3_sbrb_latch_ctrl_if.sv
// -----------------------------------------------------------------------------
// lab3_sbrb_latch_ctrl_if
//
// Request/acknowledge bundle between two requesters (A, B) and the SbRb latch
// sequencer. Each requester holds req_x high with a stable op_x/idx_x until it
// sees the one-cycle ack_x strobe.
//
// Signals:
//   req_a, req_b  request, held high until the matching ack
//   op_a,  op_b   1 = set the latch (pulse Sb), 0 = clear it (pulse Rb)
//   idx_a, idx_b  target latch index, IW bits
//   ack_a, ack_b  one-cycle completion strobe
//
// Modports:
//   master  requester side (drives req/op/idx, observes ack)
//   slave   sequencer side (observes req/op/idx, drives ack)
// -----------------------------------------------------------------------------
interface lab3_sbrb_latch_ctrl_if #(
  parameter int IW = 2
);

  logic          req_a;
  logic          op_a;
  logic [IW-1:0] idx_a;
  logic          req_b;
  logic          op_b;
  logic [IW-1:0] idx_b;
  logic          ack_a;
  logic          ack_b;

  modport master (
    output req_a, op_a, idx_a,
    output req_b, op_b, idx_b,
    input  ack_a, ack_b
  );

  modport slave (
    input  req_a, op_a, idx_a,
    input  req_b, op_b, idx_b,
    output ack_a, ack_b
  );

endinterface

// File: rtl/lab3_sbrb_latch_ctrl.sv
// -----------------------------------------------------------------------------
// lab3_sbrb_latch_ctrl
//
// Sequencer and round-robin arbiter for a bank of N gate-level active-low SbRb
// latches. A granted request drives exactly one latch with a registered
// active-low Sb (set) or Rb (clear) pulse that is PULSE_W cycles wide, then
// holds every line high for one recovery cycle, then acks the requester.
// Sb and Rb of the same latch are never low together, and at most one line of
// the whole bank is low at any time.
//
// Parameters:
//   N        number of latches (1..256)
//   IW       index width, 2**IW >= N
//   PULSE_W  active-low pulse width in cycles (1..255)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    request/ack bundle (slave modport of lab3_sbrb_latch_ctrl_if)
//   busy   high whenever the sequencer is not idle
//   sb_n   active-low set lines, one per latch
//   rb_n   active-low reset lines, one per latch
//   q_in   latch Q feedback, only consulted when write checking is built in
//   err    sticky write-check failure
//
// Build option:
//   LAB3_SBRB_VERIFY_EN  when defined, q_in[idx] is sampled in the recovery
//                        cycle and a mismatch against the requested value sets
//                        err until the next reset. When undefined, q_in is
//                        ignored and err is tied low.
// -----------------------------------------------------------------------------
module lab3_sbrb_latch_ctrl #(
  parameter int N       = 4,
  parameter int IW      = 2,
  parameter int PULSE_W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lab3_sbrb_latch_ctrl_if.slave        bus,
  output logic                         busy,
  output logic [N-1:0]                 sb_n,
  output logic [N-1:0]                 rb_n,
  input  logic [N-1:0]                 q_in,
  output logic                         err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    RECOV = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [7:0] PW_LOAD = 8'(PULSE_W);

  // One-hot select of the latch addressed by idx; all zeros when idx >= N,
  // which doubles as the out-of-range test.
  function automatic logic [N-1:0] idx_mask(input logic [IW-1:0] idx);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

  state_t        state;
  logic [7:0]    pulse_cnt;
  logic          last_b;     // 1: B was granted most recently
  logic          grant_b;    // requester owning the current operation
  logic          ack_a_q;
  logic          ack_b_q;

  // Grant data, captured once per operation; only meaningful while busy.
  logic          g_op;
  logic [N-1:0]  g_mask;

  logic          any_req;
  logic          win_b;
  logic          win_op;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_mask;
  logic          win_oob;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req  = bus.req_a | bus.req_b;
    win_b    = bus.req_b & (~bus.req_a | ~last_b);
    win_op   = win_b ? bus.op_b  : bus.op_a;
    win_idx  = win_b ? bus.idx_b : bus.idx_a;
    win_mask = idx_mask(win_idx);
    win_oob  = (win_mask == '0);
  end

  // ---- grant capture (data path, no reset) ----
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      g_op   <= win_op;
      g_mask <= win_mask;
    end
  end

  // ---- sequencer FSM (control, registered outputs) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      last_b    <= 1'b1;
      grant_b   <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      busy      <= 1'b0;
      sb_n      <= '1;
      rb_n      <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_b <= win_b;
            busy    <= 1'b1;
            if (win_oob) begin
              // Nothing to drive: acknowledge straight away.
              state   <= ACK;
              ack_a_q <= ~win_b;
              ack_b_q <= win_b;
            end else begin
              state     <= PULSE;
              pulse_cnt <= PW_LOAD;
              // Only one of the two vectors can go low, and only on one bit.
              sb_n      <= win_op ? ~win_mask : '1;
              rb_n      <= win_op ? '1 : ~win_mask;
            end
          end
        end

        PULSE: begin
          // The line went low on entry, so leaving at count 1 gives PULSE_W
          // cycles low in total.
          if (pulse_cnt <= 8'd1) begin
            state <= RECOV;
            sb_n  <= '1;
            rb_n  <= '1;
          end else begin
            pulse_cnt <= pulse_cnt - 8'd1;
          end
        end

        RECOV: begin
          state   <= ACK;
          ack_a_q <= ~grant_b;
          ack_b_q <= grant_b;
        end

        ACK: begin
          state   <= IDLE;
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          busy    <= 1'b0;
          last_b  <= grant_b;
        end

        default: begin
          state <= IDLE;
          sb_n  <= '1;
          rb_n  <= '1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_a = ack_a_q;
  assign bus.ack_b = ack_b_q;

`ifdef LAB3_SBRB_VERIFY_EN
  logic err_q;
  logic q_sel;

  // Latch output of the written bit; settled by the recovery cycle.
  assign q_sel = (q_in & g_mask) != '0;

  // ---- write check (sticky until reset) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == RECOV && q_sel != g_op) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_q_in;

  assign unused_q_in = ^q_in;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_lab3_sbrb_latch_ctrl.sv
module tb_lab3_sbrb_latch_ctrl;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int PW = 2;

`ifdef LAB3_SBRB_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         busy;
  logic         err;
  logic [N-1:0] sb_n;
  logic [N-1:0] rb_n;
  logic [N-1:0] q_in;
  logic [N-1:0] q_model = '0;
  bit           q_zero;

  lab3_sbrb_latch_ctrl_if #(.IW(IW)) bus ();

  lab3_sbrb_latch_ctrl #(.N(N), .IW(IW), .PULSE_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .sb_n  (sb_n),
    .rb_n  (rb_n),
    .q_in  (q_in),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Behavioural latch bank: Sb low sets, Rb low clears, otherwise hold.
  always @(sb_n or rb_n) begin
    for (int i = 0; i < N; i++) begin
      if (!sb_n[i])      q_model[i] = 1'b1;
      else if (!rb_n[i]) q_model[i] = 1'b0;
    end
  end
  assign q_in = q_zero ? '0 : q_model;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [N-1:0] sb_low;
    logic [N-1:0] rb_low;
    int           low;
    int           busy;
  } item_t;

  item_t qa[$];
  item_t qb[$];
  bit    ack_log[$];

  function automatic item_t mk_item(input bit op, input int idx);
    item_t it;
    it.sb_low = '0;
    it.rb_low = '0;
    it.low    = 0;
    it.busy   = 1;
    if (idx < N) begin
      if (op) it.sb_low[idx] = 1'b1;
      else    it.rb_low[idx] = 1'b1;
      it.low  = PW;
      it.busy = PW + 2;
    end
    return it;
  endfunction

  logic [N-1:0] mon_sb;
  logic [N-1:0] mon_rb;
  int           mon_low;
  int           mon_busy;
  bit           ack_prev;

  task automatic clear_mon();
    mon_sb   = '0;
    mon_rb   = '0;
    mon_low  = 0;
    mon_busy = 0;
    ack_prev = 1'b0;
  endtask

  task automatic cmp_item(input string who, input item_t it);
    chk({who, "_sb_low"},  32'(mon_sb),   32'(it.sb_low));
    chk({who, "_rb_low"},  32'(mon_rb),   32'(it.rb_low));
    chk({who, "_low_cyc"}, 32'(mon_low),  32'(it.low));
    chk({who, "_busy_cyc"}, 32'(mon_busy), 32'(it.busy));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("inv_forbidden", 32'((~sb_n & ~rb_n) != '0), 32'd0);
      chk("inv_single", 32'($countones(~(sb_n & rb_n)) > 1), 32'd0);
      if (ack_prev) begin
        chk("ack_width", 32'(bus.ack_a | bus.ack_b), 32'd0);
        chk("busy_after_ack", 32'(busy), 32'd0);
      end
      if (~(sb_n & rb_n) != '0) begin
        mon_low++;
        mon_sb = mon_sb | ~sb_n;
        mon_rb = mon_rb | ~rb_n;
      end
      if (busy) mon_busy++;
      ack_prev = bus.ack_a | bus.ack_b;
      if (bus.ack_a || bus.ack_b) begin
        item_t it;
        chk("ack_onehot", 32'(bus.ack_a & bus.ack_b), 32'd0);
        if (bus.ack_a) begin
          if (qa.size() == 0) chk("ack_a_unexpected", 32'd1, 32'd0);
          else begin
            it = qa.pop_front();
            cmp_item("a", it);
          end
        end
        if (bus.ack_b) begin
          if (qb.size() == 0) chk("ack_b_unexpected", 32'd1, 32'd0);
          else begin
            it = qb.pop_front();
            cmp_item("b", it);
          end
        end
        ack_log.push_back(bus.ack_b);
        mon_sb   = '0;
        mon_rb   = '0;
        mon_low  = 0;
        mon_busy = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ack(input bit sel, input int max, output int k);
    for (k = 1; k <= max; k++) begin
      @(negedge clk);
      if (sel ? bus.ack_b : bus.ack_a) return;
    end
    chk(sel ? "timeout_ack_b" : "timeout_ack_a", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    qa.delete();
    qb.delete();
    ack_log.delete();
    clear_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int  ka, kb, kt;
    bit  exp_order[5];

    bus.req_a = 1'b0; bus.op_a = 1'b0; bus.idx_a = '0;
    bus.req_b = 1'b0; bus.op_b = 1'b0; bus.idx_b = '0;
    q_zero = 1'b0;
    clear_mon();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_sb_n",  32'(sb_n), 32'hF);
    chk("rst_rb_n",  32'(rb_n), 32'hF);
    chk("rst_ack",   32'({bus.ack_a, bus.ack_b}), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(err),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // T1: A sets latch 2, cycle-exact timing
    qa.push_back(mk_item(1'b1, 2));
    bus.op_a = 1'b1; bus.idx_a = 3'd2; bus.req_a = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t1_sb_n_c%0d", k),  32'(sb_n), (k <= 2) ? 32'hB : 32'hF);
      chk($sformatf("t1_rb_n_c%0d", k),  32'(rb_n), 32'hF);
      chk($sformatf("t1_ack_a_c%0d", k), 32'(bus.ack_a), 32'(k == 4));
      chk($sformatf("t1_busy_c%0d", k),  32'(busy), 32'(k <= 4));
      if (k == 4) bus.req_a = 1'b0;
    end
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_qa_drained", 32'(qa.size()), 32'd0);

    // T2: simultaneous requests after reset, A wins the first tie
    do_reset();
    qa.push_back(mk_item(1'b0, 0));
    qb.push_back(mk_item(1'b1, 1));
    bus.op_a = 1'b0; bus.idx_a = 3'd0; bus.req_a = 1'b1;
    bus.op_b = 1'b1; bus.idx_b = 3'd1; bus.req_b = 1'b1;
    wait_ack(1'b0, 12, ka);
    bus.req_a = 1'b0;
    chk("t2_a_latency", 32'(ka), 32'd4);
    wait_ack(1'b1, 12, kb);
    bus.req_b = 1'b0;
    chk("t2_b_latency", 32'(ka + kb), 32'd9);
    @(negedge clk);
    chk("t2_idle_after", 32'(busy), 32'd0);
    chk("t2_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      chk("t2_first_a", 32'(ack_log[0]), 32'd0);
      chk("t2_second_b", 32'(ack_log[1]), 32'd1);
    end
    chk("t2_drained", 32'(qa.size() + qb.size()), 32'd0);

    // T3: B holds its request, A requests twice -> alternation
    do_reset();
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    fork
      begin : b_thread
        int ktb;
        bus.op_b = 1'b1; bus.idx_b = 3'd0;
        for (int n = 0; n < 3; n++) begin
          qb.push_back(mk_item(1'b1, 0));
          if (n == 0) bus.req_b = 1'b1;
          wait_ack(1'b1, 20, ktb);
        end
        bus.req_b = 1'b0;
      end
      begin : a_thread
        int kta;
        for (int m = 0; m < 2; m++) begin
          qa.push_back(mk_item(m == 0, 3));
          bus.op_a = (m == 0); bus.idx_a = 3'd3; bus.req_a = 1'b1;
          wait_ack(1'b0, 30, kta);
          bus.req_a = 1'b0;
          @(negedge clk);
        end
      end
    join
    @(negedge clk);
    chk("t3_ack_count", 32'(ack_log.size()), 32'd5);
    if (ack_log.size() == 5) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("t3_order%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
    end
    chk("t3_drained", 32'(qa.size() + qb.size()), 32'd0);
    chk("t3_err", 32'(err), 32'd0);

    // T4: out-of-range index -> immediate ack, no pulse
    do_reset();
    qa.push_back(mk_item(1'b1, 5));
    bus.op_a = 1'b1; bus.idx_a = 3'd5; bus.req_a = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("t4_ack_a_c%0d", k), 32'(bus.ack_a), 32'(k == 1));
      chk($sformatf("t4_busy_c%0d", k),  32'(busy), 32'(k == 1));
      chk($sformatf("t4_lines_c%0d", k), 32'({sb_n, rb_n}), 32'hFF);
      if (k == 1) bus.req_a = 1'b0;
    end
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_drained", 32'(qa.size()), 32'd0);

    // T5: reset during PULSE, then a normal request
    do_reset();
    qa.push_back(mk_item(1'b1, 1));
    bus.op_a = 1'b1; bus.idx_a = 3'd1; bus.req_a = 1'b1;
    @(negedge clk);
    chk("t5_pulse_low", 32'(sb_n), 32'hD);
    #2;
    rst_n = 1'b0;
    bus.req_a = 1'b0;
    qa.delete();
    clear_mon();
    #1;
    chk("t5_async_sb", 32'(sb_n), 32'hF);
    chk("t5_async_rb", 32'(rb_n), 32'hF);
    chk("t5_async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_ack", 32'(bus.ack_a | bus.ack_b), 32'd0);
    end
    qb.push_back(mk_item(1'b0, 3));
    bus.op_b = 1'b0; bus.idx_b = 3'd3; bus.req_b = 1'b1;
    wait_ack(1'b1, 10, kt);
    bus.req_b = 1'b0;
    chk("t5_after_latency", 32'(kt), 32'd4);
    @(negedge clk);
    chk("t5_drained", 32'(qa.size() + qb.size()), 32'd0);

    // T6: write check with stuck-low feedback, then good writes
    do_reset();
    q_zero = 1'b1;
    qa.push_back(mk_item(1'b1, 1));
    bus.op_a = 1'b1; bus.idx_a = 3'd1; bus.req_a = 1'b1;
    wait_ack(1'b0, 10, kt);
    bus.req_a = 1'b0;
    chk("t6_err_bad_write", 32'(err), 32'(VERIFY));
    @(negedge clk);
    q_zero = 1'b0;
    qa.push_back(mk_item(1'b1, 1));
    bus.op_a = 1'b1; bus.idx_a = 3'd1; bus.req_a = 1'b1;
    wait_ack(1'b0, 10, kt);
    bus.req_a = 1'b0;
    chk("t6_err_sticky_set", 32'(err), 32'(VERIFY));
    @(negedge clk);
    qa.push_back(mk_item(1'b0, 2));
    bus.op_a = 1'b0; bus.idx_a = 3'd2; bus.req_a = 1'b1;
    wait_ack(1'b0, 10, kt);
    bus.req_a = 1'b0;
    chk("t6_err_sticky_clr", 32'(err), 32'(VERIFY));
    @(negedge clk);
    do_reset();
    chk("t6_err_after_reset", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
